// File: rtl/calibration_sequencer.sv
// calibration_sequencer: walks every LED through the ID encoder per bit plane, settles, then triggers one camera capture (complement pass under CAL_COMPLEMENT_PASS_EN)
module calibration_sequencer #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 6,
  parameter int SETTLE_CYCLES     = 1000,
  parameter int REQ_TIMEOUT       = 256,
  localparam int NUM_BITS         = $clog2(NUM_LEDS),
  localparam int BIT_W            = $clog2(NUM_BITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic [LED_ADDRESS_WIDTH-1:0] led_request,
  output logic                         led_request_valid,
  input  logic                         color_valid,
  output logic [BIT_W-1:0]             bit_index,
  output logic                         capture_start,
  input  logic                         capture_done,
  output logic                         busy,
  output logic                         cal_done,
  output logic                         error
`ifdef CAL_COMPLEMENT_PASS_EN
  ,output logic                        invert
`endif
);
  localparam int TO_W = $clog2(REQ_TIMEOUT + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH    = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  localparam logic [LED_ADDRESS_WIDTH-1:0] LED_LAST = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0]             BIT_LAST = BIT_W'(NUM_BITS - 1);
  localparam logic [TO_W-1:0]              TO_LAST  = TO_W'(REQ_TIMEOUT - 1);
  localparam logic [ST_W-1:0]              ST_LAST  = ST_W'(SETTLE_CYCLES - 1);

  logic [2:0]                   state_q, state_d;
  logic [LED_ADDRESS_WIDTH-1:0] led_q, led_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [TO_W-1:0]              to_q, to_d;
  logic [ST_W-1:0]              st_q, st_d;
  logic                         cap_q, cap_d;
  logic                         restart, plane_done, advance;

  // capture_done is only honoured from the cycle after the capture_start pulse
  assign plane_done = state_q == S_CAPTURE && capture_done && !cap_q;
  assign restart    = !busy && start;

`ifdef CAL_COMPLEMENT_PASS_EN
  logic inv_q, inv_d;
  // invert toggles after each capture so every plane gets a normal then a complement pass
  always_comb inv_d = (abort || restart) ? 1'b0 : plane_done ? ~inv_q : inv_q;
  // invert register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inv_q <= 1'b0;
    else inv_q <= inv_d;
  assign invert  = inv_q;
  assign advance = inv_q;
`else
  assign advance = 1'b1;
`endif

  // next-state logic; abort overrides everything and restores reset values
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    bit_d   = bit_q;
    cap_d   = 1'b0;
    to_d    = (state_q == S_PUSH && !color_valid) ? to_q + 1'b1 : '0;
    st_d    = state_q == S_SETTLE ? st_q + 1'b1 : '0;
    if (abort) begin
      state_d = S_IDLE;
      led_d   = '0;
      bit_d   = '0;
      to_d    = '0;
      st_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR:
          if (start) begin
            state_d = S_PUSH;
            led_d   = '0;
            bit_d   = '0;
          end
        S_PUSH:
          if (color_valid) begin
            state_d = led_q == LED_LAST ? S_SETTLE : S_GAP;
            led_d   = led_q == LED_LAST ? '0 : led_q + 1'b1;
          end else if (to_q == TO_LAST) state_d = S_ERROR;
        S_GAP: state_d = S_PUSH;
        S_SETTLE:
          if (st_q == ST_LAST) begin
            state_d = S_CAPTURE;
            cap_d   = 1'b1;
          end
        S_CAPTURE:
          if (plane_done) begin
            state_d = (advance && bit_q == BIT_LAST) ? S_DONE : S_PUSH;
            bit_d   = (advance && bit_q != BIT_LAST) ? bit_q + 1'b1 : bit_q;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      led_q   <= '0;
      bit_q   <= '0;
      to_q    <= '0;
      st_q    <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      st_q    <= st_d;
      cap_q   <= cap_d;
    end

  assign led_request       = led_q;
  assign led_request_valid = state_q == S_PUSH;
  assign bit_index         = bit_q;
  assign capture_start     = cap_q;
  assign busy              = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign cal_done          = state_q == S_DONE;
  assign error             = state_q == S_ERROR;
endmodule
